// File: rtl/anim_rom_sequencer.sv
// Sprite animation ROM sequencer.
// Steps an animation frame counter on vsync ticks while playing, and maps scan pixels
// that fall inside the sprite window to animation ROM addresses. The ROM colour comes
// back with a hit flag. A colour-keyed ROM word counts as a miss.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   vsync_tick          one-cycle pulse per video frame
//   play                one-cycle pulse, starts the animation
//   pix_valid/x/y       scan pixel (active video)
//   spr_x/spr_y         sprite origin (top-left)
//   rom_addr/rom_data   animation ROM read port (ROM_LAT cycles addr -> data)
//   pix_rgb/pix_hit     sprite colour and opaque-hit flag (1+1+ROM_LAT cycles after pix_*)
//   frame_idx           current animation frame
//   anim_busy           high while playing
//   anim_done           one-cycle pulse when the last frame has been shown
module anim_rom_sequencer #(
    parameter int unsigned SPR_W           = 64,
    parameter int unsigned SPR_H           = 128,
    parameter int unsigned N_FRAMES        = 15,
    parameter int unsigned TICKS_PER_FRAME = 4,
    parameter int unsigned ROM_LAT         = 1,
    parameter logic [11:0] TRANSPARENT     = 12'hF0F,
    parameter int unsigned ADDR_W          = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync_tick,
    input  logic              play,
    input  logic              pix_valid,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic [9:0]        spr_x,
    input  logic [9:0]        spr_y,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic [11:0]       pix_rgb,
    output logic              pix_hit,
    output logic [3:0]        frame_idx,
    output logic              anim_busy,
    output logic              anim_done
);

    localparam int unsigned LOG_W  = $clog2(SPR_W);
    localparam int unsigned TICK_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

    localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(TICKS_PER_FRAME - 1);
    localparam logic [3:0]        LAST_FRAME = 4'(N_FRAMES - 1);
    localparam logic [10:0]       WIN_W      = 11'(SPR_W);
    localparam logic [10:0]       WIN_H      = 11'(SPR_H);
    localparam logic [ADDR_W-1:0] FRAME_STEP = ADDR_W'(SPR_W * SPR_H);

    typedef enum logic {StIdle, StPlay} state_t;

    state_t              state_q;
    logic [TICK_W-1:0]   tick_cnt_q;
    // Base address of the current frame, kept in step with frame_idx so the frame
    // offset never needs a multiply.
    logic [ADDR_W-1:0]   frame_base_q;
    logic [ROM_LAT:0]    hit_pipe_q;

    logic [10:0]         dx, dy;
    logic                in_win;
    logic [ADDR_W-1:0]   addr_calc;
    logic                hit_out;

    // ------------------------------------------------------------------
    // Animation FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            tick_cnt_q   <= '0;
            frame_idx    <= '0;
            frame_base_q <= '0;
            anim_busy    <= 1'b0;
            anim_done    <= 1'b0;
        end else begin
            anim_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    tick_cnt_q   <= '0;
                    frame_idx    <= '0;
                    frame_base_q <= '0;
                    if (play) begin
                        state_q   <= StPlay;
                        anim_busy <= 1'b1;
                    end
                end
                StPlay: begin
                    if (vsync_tick) begin
                        if (tick_cnt_q < LAST_TICK) begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end else begin
                            tick_cnt_q <= '0;
                            if (frame_idx < LAST_FRAME) begin
                                frame_idx    <= frame_idx + 1'b1;
                                frame_base_q <= frame_base_q + FRAME_STEP;
                            end else begin
                                anim_done    <= 1'b1;
                                frame_idx    <= '0;
                                frame_base_q <= '0;
                                // play on the end event restarts without leaving PLAY
                                if (!play) begin
                                    state_q   <= StIdle;
                                    anim_busy <= 1'b0;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    anim_busy <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline
    // ------------------------------------------------------------------
    always_comb begin
        // 11-bit two's complement offsets; bit 10 set means left of / above origin
        dx        = {1'b0, pix_x} - {1'b0, spr_x};
        dy        = {1'b0, pix_y} - {1'b0, spr_y};
        in_win    = pix_valid && !dx[10] && (dx < WIN_W) && !dy[10] && (dy < WIN_H);
        addr_calc = frame_base_q
                  + (ADDR_W'(dy[9:0]) << LOG_W)
                  + ADDR_W'(dx[9:0]);
        hit_out   = hit_pipe_q[ROM_LAT] && (rom_data != TRANSPARENT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr   <= '0;
            hit_pipe_q <= '0;
            pix_hit    <= 1'b0;
            pix_rgb    <= '0;
        end else begin
            if (in_win) begin
                rom_addr <= addr_calc;
            end
            hit_pipe_q[0] <= in_win;
            for (int i = 1; i <= int'(ROM_LAT); i++) begin
                hit_pipe_q[i] <= hit_pipe_q[i-1];
            end
            pix_hit <= hit_out;
            pix_rgb <= hit_out ? rom_data : 12'h000;
        end
    end

endmodule

// File: tb/tb_anim_rom_sequencer.sv
// Self-checking bench for anim_rom_sequencer: animation FSM against a small frame/tick
// model, pixel pipeline against a scoreboard of expected {hit, rgb} per driven pixel.
module tb_anim_rom_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync_tick, play, pix_valid;
    logic [9:0]  pix_x, pix_y, spr_x, spr_y;
    logic [16:0] rom_addr;
    logic [11:0] rom_data, pix_rgb;
    logic        pix_hit;
    logic [3:0]  frame_idx;
    logic        anim_busy, anim_done;

    always #5 clk = ~clk;

    anim_rom_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .vsync_tick (vsync_tick),
        .play       (play),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pix_rgb    (pix_rgb),
        .pix_hit    (pix_hit),
        .frame_idx  (frame_idx),
        .anim_busy  (anim_busy),
        .anim_done  (anim_done)
    );

    // ROM model, one cycle read latency
    logic [16:0] transp_addr = 17'h1FFFF;

    function automatic logic [11:0] rom_fn(input logic [16:0] a);
        if (a == 17'd16586) return 12'h0A5;
        if (a == transp_addr) return 12'hF0F;
        return a[11:0] ^ {a[16:12], 7'h35};
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    // Model state and scoreboard
    logic [12:0] sb[$];
    logic [12:0] e;
    int          m_frame, m_tick;
    logic        m_busy, m_done;
    logic [16:0] exp_addr;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt;

    task automatic ctl_cycle(input logic t, input logic p);
        vsync_tick = t;
        play       = p;
        pix_valid  = 1'b0;
        m_done     = 1'b0;
        if (!m_busy) begin
            if (p) begin
                m_busy = 1'b1; m_frame = 0; m_tick = 0;
            end
        end else if (t) begin
            if (m_tick < 3) m_tick++;
            else begin
                m_tick = 0;
                if (m_frame < 14) m_frame++;
                else begin
                    m_done = 1'b1; m_frame = 0; m_busy = p;
                end
            end
        end
        @(posedge clk); #1;
        vsync_tick = 1'b0;
        play       = 1'b0;
    endtask

    task automatic drive_pix(input int x, input int y, input logic v);
        int dx, dy;
        logic hit, oh;
        logic [16:0] a;
        logic [11:0] c;
        vsync_tick = 1'b0;
        play       = 1'b0;
        pix_x      = 10'(x);
        pix_y      = 10'(y);
        pix_valid  = v;
        dx  = x - int'(spr_x);
        dy  = y - int'(spr_y);
        hit = v && dx >= 0 && dx < 64 && dy >= 0 && dy < 128;
        a   = 17'(m_frame * 8192 + dy * 64 + dx);
        oh  = 1'b0;
        c   = 12'h000;
        if (hit) begin
            exp_addr = a;
            c  = rom_fn(a);
            oh = (c != 12'hF0F);
        end
        sb.push_back({oh, oh ? c : 12'h000});
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        pix_valid  = 1'b0;
        vsync_tick = 1'b0;
        play       = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; vsync_tick = 0; play = 0; pix_valid = 0;
        pix_x = 0; pix_y = 0; spr_x = 10'd100; spr_y = 10'd200;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (frame_idx !== 4'd0) begin n_bad++; $display("FAIL reset frame_idx: got %0d want 0", frame_idx); end
        n_cmp++; if (anim_busy !== 1'b0) begin n_bad++; $display("FAIL reset anim_busy: got %b want 0", anim_busy); end
        n_cmp++; if (anim_done !== 1'b0) begin n_bad++; $display("FAIL reset anim_done: got %b want 0", anim_done); end
        n_cmp++; if (rom_addr !== 17'd0) begin n_bad++; $display("FAIL reset rom_addr: got %0d want 0", rom_addr); end
        n_cmp++; if (pix_hit !== 1'b0) begin n_bad++; $display("FAIL reset pix_hit: got %b want 0", pix_hit); end
        n_cmp++; if (pix_rgb !== 12'h000) begin n_bad++; $display("FAIL reset pix_rgb: got %h want 000", pix_rgb); end
        rst = 1'b0;
        m_frame = 0; m_tick = 0; m_busy = 0; m_done = 0; exp_addr = 0;
    endtask

    task automatic test_full_animation();
        done_cnt = 0;
        ctl_cycle(1'b0, 1'b1);
        n_cmp++; if (anim_busy !== 1'b1) begin n_bad++; $display("FAIL full_anim start busy: got %b want 1", anim_busy); end
        for (int t = 1; t <= 60; t++) begin
            ctl_cycle(1'b1, 1'b0);
            if (anim_done) done_cnt++;
            if (t < 60) begin
                n_cmp++; if (frame_idx !== 4'(t / 4)) begin n_bad++; $display("FAIL full_anim frame tick %0d: got %0d want %0d", t, frame_idx, t / 4); end
                n_cmp++; if (anim_done !== 1'b0) begin n_bad++; $display("FAIL full_anim early done tick %0d: got %b want 0", t, anim_done); end
            end else begin
                n_cmp++; if (anim_done !== 1'b1) begin n_bad++; $display("FAIL full_anim done: got %b want 1", anim_done); end
                n_cmp++; if (anim_busy !== 1'b0) begin n_bad++; $display("FAIL full_anim busy end: got %b want 0", anim_busy); end
                n_cmp++; if (frame_idx !== 4'd0) begin n_bad++; $display("FAIL full_anim frame end: got %0d want 0", frame_idx); end
            end
            ctl_cycle(1'b0, 1'b0);
            if (anim_done) done_cnt++;
        end
        // IDLE ignores ticks
        ctl_cycle(1'b1, 1'b0);
        n_cmp++; if ({anim_busy, frame_idx} !== 5'd0) begin n_bad++; $display("FAIL full_anim idle tick: got busy %b frame %0d want 0/0", anim_busy, frame_idx); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL full_anim done count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_play_collisions();
        ctl_cycle(1'b0, 1'b1);
        for (int k = 0; k < 59; k++) begin
            // k==21/22: play while at frame 5 (no end event) must be ignored
            ctl_cycle(1'b1, (k == 21) || (k == 22));
            n_cmp++;
            if ({anim_busy, anim_done, frame_idx} !== {m_busy, m_done, 4'(m_frame)}) begin
                n_bad++;
                $display("FAIL collide step %0d: got busy %b done %b frame %0d want %b %b %0d",
                         k, anim_busy, anim_done, frame_idx, m_busy, m_done, m_frame);
            end
        end
        ctl_cycle(1'b1, 1'b1);
        n_cmp++; if (anim_done !== 1'b1) begin n_bad++; $display("FAIL collide end done: got %b want 1", anim_done); end
        n_cmp++; if (anim_busy !== 1'b1) begin n_bad++; $display("FAIL collide end busy: got %b want 1", anim_busy); end
        n_cmp++; if (frame_idx !== 4'd0) begin n_bad++; $display("FAIL collide end frame: got %0d want 0", frame_idx); end
        done_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            ctl_cycle(1'b1, 1'b0);
            if (anim_done) done_cnt++;
            n_cmp++;
            if ({anim_busy, anim_done, frame_idx} !== {m_busy, m_done, 4'(m_frame)}) begin
                n_bad++;
                $display("FAIL rerun step %0d: got busy %b done %b frame %0d want %b %b %0d",
                         k, anim_busy, anim_done, frame_idx, m_busy, m_done, m_frame);
            end
        end
        n_cmp++; if (done_cnt !== 1 || anim_busy !== 1'b0) begin n_bad++; $display("FAIL rerun end: got done_cnt %0d busy %b want 1/0", done_cnt, anim_busy); end
    endtask

    task automatic test_address_map();
        ctl_cycle(1'b0, 1'b1);
        repeat (8) ctl_cycle(1'b1, 1'b0);
        n_cmp++; if (frame_idx !== 4'd2) begin n_bad++; $display("FAIL addr_map frame: got %0d want 2", frame_idx); end
        spr_x = 10'd100; spr_y = 10'd200;
        for (int i = 0; i < 3; i++) begin
            if (i < 1) drive_pix(110, 203, 1'b1); else idle_cycle();
            if (i == 0) begin
                n_cmp++; if (rom_addr !== 17'd16586) begin n_bad++; $display("FAIL addr_map rom_addr: got %0d want 16586", rom_addr); end
            end
            if (i >= 2) begin
                e = sb.pop_front();
                n_cmp++; if ({pix_hit, pix_rgb} !== e) begin n_bad++; $display("FAIL addr_map pixel: got hit %b rgb %h want %b %h", pix_hit, pix_rgb, e[12], e[11:0]); end
                n_cmp++; if (pix_rgb !== 12'h0A5) begin n_bad++; $display("FAIL addr_map rgb: got %h want 0a5", pix_rgb); end
            end
        end
    endtask

    task automatic test_window_edges();
        int xs[7];
        int ys[7];
        logic vs[7];
        xs = '{163, 100, 164, 99, 120, 120, 110};
        ys = '{327, 200, 250, 250, 199, 250, 203};
        vs = '{1, 1, 1, 1, 1, 0, 1};
        for (int i = 0; i < 9; i++) begin
            if (i < 7) drive_pix(xs[i], ys[i], vs[i]); else idle_cycle();
            n_cmp++; if (rom_addr !== exp_addr) begin n_bad++; $display("FAIL edges rom_addr step %0d: got %0d want %0d", i, rom_addr, exp_addr); end
            if (i == 0) begin
                n_cmp++; if (rom_addr !== 17'd24575) begin n_bad++; $display("FAIL edges far corner addr: got %0d want 24575", rom_addr); end
            end
            if (i == 1) begin
                n_cmp++; if (rom_addr !== 17'd16384) begin n_bad++; $display("FAIL edges origin addr: got %0d want 16384", rom_addr); end
            end
            if (i >= 2) begin
                e = sb.pop_front();
                n_cmp++; if ({pix_hit, pix_rgb} !== e) begin n_bad++; $display("FAIL edges pixel %0d: got hit %b rgb %h want %b %h", i - 2, pix_hit, pix_rgb, e[12], e[11:0]); end
            end
        end
    endtask

    task automatic test_transparency();
        transp_addr = 17'(2 * 8192 + 5 * 64 + 7);
        for (int i = 0; i < 5; i++) begin
            if (i == 0 || i == 2) drive_pix(107, 205, 1'b1);
            else if (i == 1) drive_pix(108, 205, 1'b1);
            else idle_cycle();
            n_cmp++; if (rom_addr !== exp_addr) begin n_bad++; $display("FAIL transp rom_addr step %0d: got %0d want %0d", i, rom_addr, exp_addr); end
            if (i >= 2) begin
                e = sb.pop_front();
                n_cmp++; if ({pix_hit, pix_rgb} !== e) begin n_bad++; $display("FAIL transp pixel %0d: got hit %b rgb %h want %b %h", i - 2, pix_hit, pix_rgb, e[12], e[11:0]); end
                if (i == 2 || i == 4) begin
                    n_cmp++; if ({pix_hit, pix_rgb} !== 13'd0) begin n_bad++; $display("FAIL transp keyed: got hit %b rgb %h want 0 000", pix_hit, pix_rgb); end
                end
            end
        end
        transp_addr = 17'h1FFFF;
    endtask

    task automatic test_reset_midop();
        repeat (20) ctl_cycle(1'b1, 1'b0);
        n_cmp++; if (frame_idx !== 4'd7) begin n_bad++; $display("FAIL midrst frame before: got %0d want 7", frame_idx); end
        drive_pix(110, 203, 1'b1);
        drive_pix(111, 203, 1'b1);
        rst = 1'b1; pix_valid = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        m_frame = 0; m_tick = 0; m_busy = 0; m_done = 0; exp_addr = 0;
        n_cmp++; if ({anim_busy, anim_done, frame_idx} !== 6'd0) begin n_bad++; $display("FAIL midrst fsm: got busy %b done %b frame %0d want 0", anim_busy, anim_done, frame_idx); end
        n_cmp++; if ({pix_hit, pix_rgb, rom_addr} !== 30'd0) begin n_bad++; $display("FAIL midrst pixel: got hit %b rgb %h addr %0d want 0", pix_hit, pix_rgb, rom_addr); end
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            n_cmp++; if ({pix_hit, anim_done} !== 2'b00) begin n_bad++; $display("FAIL midrst flight %0d: got hit %b done %b want 0 0", i, pix_hit, anim_done); end
        end
        for (int i = 0; i < 8; i++) begin
            ctl_cycle(1'b1, 1'b0);
            n_cmp++; if ({anim_busy, frame_idx} !== 5'd0) begin n_bad++; $display("FAIL midrst idle tick %0d: got busy %b frame %0d want 0", i, anim_busy, frame_idx); end
        end
        ctl_cycle(1'b0, 1'b1);
        repeat (4) ctl_cycle(1'b1, 1'b0);
        n_cmp++; if (frame_idx !== 4'd1 || anim_busy !== 1'b1) begin n_bad++; $display("FAIL midrst replay: got frame %0d busy %b want 1 1", frame_idx, anim_busy); end
    endtask

    initial begin
        test_reset();
        test_full_animation();
        test_play_collisions();
        test_address_map();
        test_window_edges();
        test_transparency();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/anim_rom_sequencer.md
Name: anim_rom_sequencer

Overview:
- Sequences reads from a multi-frame sprite animation ROM: 15 frames of 12-bit RGB, 17-bit word address, synchronous read.
- Holds a frame counter that steps on video-frame ticks while an animation plays.
- Maps each scan pixel inside the sprite window to a ROM address, then returns the pixel colour with a hit flag.
- Sits between the VGA timing/scan logic and the animation ROM instance, in front of the display mixer.

Parameters:
- SPR_W, 64, sprite width in pixels (power of two).
- SPR_H, 128, sprite height in pixels.
- N_FRAMES, 15, number of animation frames stored back-to-back in the ROM.
- TICKS_PER_FRAME, 4, vsync ticks each frame is shown.
- ROM_LAT, 1, ROM read latency in cycles (addr to data).
- TRANSPARENT, 12'hF0F, colour key treated as no-hit.
- ADDR_W, 17, ROM address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- vsync_tick  in  1  one-cycle pulse per video frame.
- play  in  1  one-cycle pulse: start animation.
- pix_valid  in  1  pix_x/pix_y valid this cycle (active video).
- pix_x  in  10  scan column.
- pix_y  in  10  scan row.
- spr_x  in  10  sprite origin column (top-left).
- spr_y  in  10  sprite origin row.
- rom_addr  out  ADDR_W  address to ROM addra.
- rom_data  in  12  ROM douta.
- pix_rgb  out  12  sprite colour; 0 when pix_hit=0.
- pix_hit  out  1  opaque sprite pixel present.
- frame_idx  out  4  current frame, 0..N_FRAMES-1.
- anim_busy  out  1  high while in PLAY.
- anim_done  out  1  one-cycle pulse at animation end.

Behaviour:
- Reset values: frame_idx=0, tick_cnt=0, state=IDLE, rom_addr=0, pix_rgb=0, pix_hit=0, anim_busy=0, anim_done=0. All pipeline valid bits are cleared.
- Reset mid-animation aborts immediately. Any in-flight pixel results are discarded, and no anim_done is generated.
- FSM state IDLE:
  - frame_idx=0.
  - play moves to PLAY with tick_cnt=0 and frame_idx=0.
- FSM state PLAY:
  - anim_busy=1.
  - On vsync_tick, if tick_cnt<TICKS_PER_FRAME-1, then tick_cnt++.
  - Otherwise tick_cnt=0, and:
    - if frame_idx<N_FRAMES-1: frame_idx++;
    - else: anim_done=1 for one cycle, state goes to IDLE, frame_idx=0.
- Rules for play and vsync_tick:
  - play while in PLAY without the end event is ignored.
  - play in the same cycle as the end event: anim_done pulses and the FSM restarts (PLAY, frame 0, tick_cnt 0); anim_busy stays 1.
  - vsync_tick in IDLE is ignored.
- Frame changes occur only on vsync_tick, so no frame mixes two animation frames.
- Pixel pipeline stage 1, registered at cycle N+1 for inputs at cycle N:
  - dx = pix_x - spr_x and dy = pix_y - spr_y, computed as 11-bit signed.
  - hit = pix_valid && 0<=dx<SPR_W && 0<=dy<SPR_H.
  - If hit: rom_addr = frame_idx*SPR_W*SPR_H + dy*SPR_W + dx. Use shifts and adds only; no multiplier inferred for SPR_W.
  - If not hit: rom_addr holds its previous value.
  - hit is carried in a delay line of 1+ROM_LAT stages.
- Pixel pipeline output stage, registered at cycle N+2+ROM_LAT:
  - pix_hit = hit_d && rom_data!=TRANSPARENT.
  - pix_rgb = pix_hit ? rom_data : 0.
  - Fixed latency is 3 cycles from pix_* to pix_rgb at default ROM_LAT.
- frame_idx is sampled in stage 1. A frame change on cycle N affects pixels presented on cycle N or later. Pixels already in flight keep the old frame.
- Negative dx/dy (pixel left of or above the origin) is a miss.
- Sprite partly off-screen needs no special handling: no wrap-around, and addresses are only formed for in-window pixels.
- Maximum address is N_FRAMES*SPR_W*SPR_H-1 = 122879, which fits 17 bits.

Test Plan:
- Address mapping:
  - Stimulus: reset, play, advance to frame_idx=2; spr=(100,200), pixel (110,203) with pix_valid=1.
  - Response: rom_addr=16586 one cycle later; pix_hit=1 and pix_rgb=rom_data three cycles after input (rom model returns 12'h0A5).
- Window edges (spr=(100,200)):
  - Pixels (163,327) and (100,200) give hits, at addresses frame_base+8191 and frame_base+0.
  - Pixels (164,250), (99,250) and (120,199) give pix_hit=0, pix_rgb=0, and rom_addr unchanged.
- Transparency:
  - Stimulus: in-window pixel, rom returns 12'hF0F.
  - Response: pix_hit=0, pix_rgb=0.
- Full animation:
  - Stimulus: play, then 60 vsync_ticks.
  - Response: frame_idx steps 0→14 every 4 ticks; anim_done pulses exactly once, at the cycle after the 60th tick; anim_busy falls at the same point; frame_idx=0.
- play collisions:
  - play during PLAY at frame 5 → ignored, frame sequence unchanged.
  - play coincident with the final tick → anim_done=1, anim_busy stays 1, frame_idx=0, a new 60-tick run follows.
- Reset mid-op:
  - Stimulus: rst at frame 7 with pixels in flight.
  - Response: next cycle all outputs 0, frame_idx=0, no anim_done; the following vsync_ticks do not advance frame_idx until play.
